conf_loader: RTL and testbench
==============================

Name: conf_loader

Overview:
- Sits directly downstream of the UART receiver in the DRSSTC controller.
- Consumes the receiver's byte, its slot address and its one-cycle data-ready pulse.
- Assembles a complete 6-byte configuration frame in shadow registers, then atomically transfers it to the active parameter set used by the interrupter/timing logic.
- The transfer happens only when the coil is in a safe (non-firing) window.

Parameters:
- N_PAR, 6, number of configuration bytes per frame; slot addresses run N_PAR-1 down to 0.
- DATA_W, 8, byte width.
- ADDR_W, 3, slot address width; must satisfy 2**ADDR_W >= N_PAR.
- TIMEOUT_MAX, 4160, maximum clk cycles allowed between consecutive bytes of one frame (about four UART byte times).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- data_in  in  DATA_W  received byte (receiver storage).
- addr_in  in  ADDR_W  slot address of data_in (receiver conf_par_cnt).
- data_valid  in  1  one-cycle pulse; data_in/addr_in valid.
- safe  in  1  high while the coil is not firing; commit is allowed.
- params  out  N_PAR*DATA_W  active parameter set; slot k occupies bits [k*DATA_W +: DATA_W].
- cfg_valid  out  1  sticky; high once at least one frame has been committed.
- commit  out  1  one-cycle pulse on the cycle params updates.
- frame_err  out  1  one-cycle pulse on an address mismatch, timeout, overrun or checksum failure.
- pending  out  1  high while a complete frame waits for safe.

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: params=0, cfg_valid=0, commit=0, frame_err=0, pending=0; shadow=0; state=IDLE; expected address exp=N_PAR-1; gap counter=0.
- Reset mid-frame or while pending: the partial or pending frame is lost, and params returns to 0.
- States:
  - IDLE: waiting for a byte with addr_in=N_PAR-1.
  - LOAD: frame in progress.
  - PENDING: complete frame held, waiting for safe.
- IDLE:
  - data_valid with addr_in=N_PAR-1: write shadow[N_PAR-1], set exp=N_PAR-2, go to LOAD.
  - Any other address: frame_err pulse, stay in IDLE. This resynchronises to the receiver's free-running address.
- LOAD, data_valid with addr_in=exp: write shadow[exp] and decrement exp.
  - If exp was 0: go to PENDING and set pending=1.
- LOAD, data_valid with addr_in!=exp: frame_err pulse, then the byte is handled exactly as in IDLE in the same cycle (addr N_PAR-1 restarts the frame; otherwise go to IDLE).
- Timeout: the gap counter clears on each accepted byte and increments every cycle in LOAD. If it reaches TIMEOUT_MAX: frame_err pulse, go to IDLE, exp=N_PAR-1.
- PENDING with safe=1: params<=shadow, commit=1 for one cycle, cfg_valid<=1, pending<=0, go to IDLE. Latency from safe high to params valid is one cycle.
- PENDING with data_valid and safe=0 (overrun): the pending frame is discarded, frame_err pulse, and the byte is processed as in IDLE.
- PENDING with data_valid and safe=1 in the same cycle: the commit uses the old shadow (non-blocking copy), and the byte is then processed as in IDLE. No frame_err.
- data_valid never re-asserts on consecutive cycles. The block does not require this, and it must not misbehave if it happens.
- All outputs are registered.

Optional Feature:
- Macro: CONF_LOADER_CHECKSUM_EN.
- When defined:
  - An XOR accumulator clears on the slot N_PAR-1 byte and accumulates bytes N_PAR-1..1.
  - The slot-0 byte is a checksum. On match, go to PENDING. On mismatch, frame_err pulse, go to IDLE, no pending.
  - params slot 0 is always driven 0.
- When undefined: slot 0 is an ordinary parameter and no check is made.

Decomposition:
- Package conf_pkg: N_PAR, DATA_W, ADDR_W, FIRST_ADDR=N_PAR-1, the state enum (IDLE, LOAD, PENDING), and an address typedef. These are shared with the UART receiver's address counter.
- One sub-module, gap_timer:
  - Parameter TIMEOUT_MAX; inputs clk, rst, clr, run; output expired.
  - Saturating counter: expired asserts when the count reaches TIMEOUT_MAX.

Test Plan:
- Bytes 11,22,33,44,55,66 at addrs 5..0 with safe=1 -> commit pulse one cycle after the addr-0 byte; params=0x112233445566 (slot5..slot0); cfg_valid=1; no frame_err.
- Same frame with safe=0, then safe raised 500 cycles later -> pending=1 until safe is raised; commit on the next cycle; params updated only then.
- Bytes at addrs 5,4,2 -> frame_err on the addr-2 byte, state IDLE. A following full frame at addrs 5..0 commits correctly.
- Addrs 5,4 then a gap of 4200 cycles -> frame_err at cycle 4160 of the gap; the late addr-3 byte gives frame_err; params unchanged.
- Frame pending with safe=0, then a new byte at addr 5 -> frame_err, pending=0, new frame starts. Repeat with safe=1 in the same cycle -> commit of the old frame, no frame_err.
- CONF_LOADER_CHECKSUM_EN: bytes 01,02,04,08,10, checksum 1F -> commit. Same with checksum 1E -> frame_err, no commit.
- Assert rst mid-LOAD and while pending -> all outputs 0 immediately (asynchronously).

Source files
------------

// File: rtl/conf_pkg.sv
// Shared configuration-frame definitions for conf_loader and the UART receiver's slot counter.
package conf_pkg;

    localparam int N_PAR      = 6;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = 3;
    localparam int FIRST_ADDR = N_PAR - 1;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PENDING
    } state_t;

endpackage

// File: rtl/gap_timer.sv
// Saturating inter-byte gap counter; expired holds while the count sits at TIMEOUT_MAX.
module gap_timer #(
    parameter int TIMEOUT_MAX = 4160
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_MAX + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (run && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == CW'(TIMEOUT_MAX));

endmodule

// File: rtl/conf_loader.sv
// Assembles a 6-byte configuration frame from the UART receiver and commits it during a safe window.
// Optional slot-0 XOR checksum is enabled by defining CONF_LOADER_CHECKSUM_EN.
module conf_loader
    import conf_pkg::*;
#(
    parameter int TIMEOUT_MAX = 4160
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         data_in,
    input  logic [ADDR_W-1:0]         addr_in,
    input  logic                      data_valid,
    input  logic                      safe,
    output logic [N_PAR*DATA_W-1:0]   params,
    output logic                      cfg_valid,
    output logic                      commit,
    output logic                      frame_err,
    output logic                      pending
);

    localparam addr_t FIRST = addr_t'(FIRST_ADDR);

    state_t                    state, state_n;
    addr_t                     exp_addr, exp_addr_n;
    logic [N_PAR*DATA_W-1:0]   shadow, shadow_n;
    logic [N_PAR*DATA_W-1:0]   params_n;
    logic                      cfg_valid_n, commit_n, frame_err_n, pending_n;
    logic                      take_byte;
    logic                      expired;
`ifdef CONF_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]         csum, csum_n;
`endif

    // Any accepted byte, or being outside a frame, restarts the gap measurement.
    gap_timer #(
        .TIMEOUT_MAX (TIMEOUT_MAX)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (data_valid || (state != LOAD)),
        .run     (state == LOAD),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            exp_addr  <= FIRST;
            shadow    <= '0;
            params    <= '0;
            cfg_valid <= 1'b0;
            commit    <= 1'b0;
            frame_err <= 1'b0;
            pending   <= 1'b0;
`ifdef CONF_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            state     <= state_n;
            exp_addr  <= exp_addr_n;
            shadow    <= shadow_n;
            params    <= params_n;
            cfg_valid <= cfg_valid_n;
            commit    <= commit_n;
            frame_err <= frame_err_n;
            pending   <= pending_n;
`ifdef CONF_LOADER_CHECKSUM_EN
            csum      <= csum_n;
`endif
        end
    end

    // take_byte marks cases where the incoming byte is treated as if seen from IDLE.
    always_comb begin
        state_n     = state;
        exp_addr_n  = exp_addr;
        shadow_n    = shadow;
        params_n    = params;
        cfg_valid_n = cfg_valid;
        commit_n    = 1'b0;
        frame_err_n = 1'b0;
        pending_n   = pending;
        take_byte   = 1'b0;
`ifdef CONF_LOADER_CHECKSUM_EN
        csum_n      = csum;
`endif

        unique case (state)
            IDLE: begin
                take_byte = 1'b1;
            end
            LOAD: begin
                if (data_valid) begin
                    if (addr_in == exp_addr) begin
                        shadow_n[int'(exp_addr)*DATA_W +: DATA_W] = data_in;
                        if (exp_addr == '0) begin
                            exp_addr_n = FIRST;
`ifdef CONF_LOADER_CHECKSUM_EN
                            if (data_in == csum) begin
                                state_n   = PENDING;
                                pending_n = 1'b1;
                            end else begin
                                state_n     = IDLE;
                                frame_err_n = 1'b1;
                            end
`else
                            state_n   = PENDING;
                            pending_n = 1'b1;
`endif
                        end else begin
                            exp_addr_n = exp_addr - 1'b1;
`ifdef CONF_LOADER_CHECKSUM_EN
                            csum_n = csum ^ data_in;
`endif
                        end
                    end else begin
                        frame_err_n = 1'b1;
                        take_byte   = 1'b1;
                    end
                end else if (expired) begin
                    frame_err_n = 1'b1;
                    state_n     = IDLE;
                    exp_addr_n  = FIRST;
                end
            end
            PENDING: begin
                if (safe) begin
`ifdef CONF_LOADER_CHECKSUM_EN
                    params_n = {shadow[N_PAR*DATA_W-1:DATA_W], {DATA_W{1'b0}}};
`else
                    params_n = shadow;
`endif
                    commit_n    = 1'b1;
                    cfg_valid_n = 1'b1;
                    pending_n   = 1'b0;
                    state_n     = IDLE;
                    take_byte   = 1'b1;
                end else if (data_valid) begin
                    frame_err_n = 1'b1;
                    pending_n   = 1'b0;
                    state_n     = IDLE;
                    take_byte   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        // Only the first slot can open a frame; anything else resynchronises to IDLE.
        if (take_byte && data_valid) begin
            if (addr_in == FIRST) begin
                shadow_n[FIRST_ADDR*DATA_W +: DATA_W] = data_in;
                exp_addr_n = FIRST - 1'b1;
                state_n    = LOAD;
                pending_n  = 1'b0;
`ifdef CONF_LOADER_CHECKSUM_EN
                csum_n = data_in;
`endif
            end else begin
                frame_err_n = 1'b1;
                state_n     = IDLE;
                exp_addr_n  = FIRST;
            end
        end
    end

endmodule

// File: tb/tb_conf_loader.sv
// Directed self-checking bench for conf_loader; checksum cases follow CONF_LOADER_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_conf_loader;

    logic        clk;
    logic        rst;
    logic [7:0]  data_in;
    logic [2:0]  addr_in;
    logic        data_valid;
    logic        safe;
    logic [47:0] params;
    logic        cfg_valid;
    logic        commit;
    logic        frame_err;
    logic        pending;

    int compare_cnt  = 0;
    int mismatch_cnt = 0;

    conf_loader #(.TIMEOUT_MAX(4160)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .addr_in    (addr_in),
        .data_valid (data_valid),
        .safe       (safe),
        .params     (params),
        .cfg_valid  (cfg_valid),
        .commit     (commit),
        .frame_err  (frame_err),
        .pending    (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compare_cnt++;
        if (observed !== expected) begin
            mismatch_cnt++;
            $display("[TB] FAIL %s: observed 0x%0h, required 0x%0h", tag, observed, expected);
        end
    endtask

    // One byte with an idle cycle before it; returns at the negedge after capture.
    task automatic applyStimulus(input logic [2:0] addr, input logic [7:0] data);
        @(negedge clk);
        addr_in    = addr;
        data_in    = data;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
    endtask

    function automatic logic [47:0] frameExpect(input logic [47:0] f);
`ifdef CONF_LOADER_CHECKSUM_EN
        return {f[47:8], 8'h00};
`else
        return f;
`endif
    endfunction

    task automatic sendSlots(input logic [47:0] f, input int hi);
        logic [7:0] b;
        for (int s = hi; s >= 0; s--) begin
            b = f[s*8 +: 8];
`ifdef CONF_LOADER_CHECKSUM_EN
            if (s == 0) b = f[47:40] ^ f[39:32] ^ f[31:24] ^ f[23:16] ^ f[15:8];
`endif
            applyStimulus(3'(s), b);
            checkOutput("good_byte_no_err", 64'(frame_err), 64'd0);
        end
    endtask

    localparam logic [47:0] F1 = 48'h112233445566;
    localparam logic [47:0] F2 = 48'hA55A3CC30FF0;
    localparam logic [47:0] F3 = 48'hDEADBEEFCAFE;
    localparam logic [47:0] F4 = 48'h123456789ABC;
    localparam logic [47:0] F5 = 48'h0F1E2D3C4B5A;
    localparam logic [47:0] F6 = 48'hFEDCBA987654;
    localparam logic [47:0] F7 = 48'h5555AAAA1234;

    initial begin
        int  k;
        logic saw_commit;

        rst        = 1'b1;
        data_in    = '0;
        addr_in    = '0;
        data_valid = 1'b0;
        safe       = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset_params",    64'(params),    64'd0);
        checkOutput("reset_cfg_valid", 64'(cfg_valid), 64'd0);
        checkOutput("reset_commit",    64'(commit),    64'd0);
        checkOutput("reset_frame_err", 64'(frame_err), 64'd0);
        checkOutput("reset_pending",   64'(pending),   64'd0);
        rst = 1'b0;

        $display("[TB] full frame with safe high");
        safe = 1'b1;
        sendSlots(F1, 5);
        checkOutput("f1_pending_set", 64'(pending), 64'd1);
        checkOutput("f1_no_early_commit", 64'(commit), 64'd0);
        @(negedge clk);
        checkOutput("f1_commit", 64'(commit), 64'd1);
        checkOutput("f1_params", 64'(params), 64'(frameExpect(F1)));
        checkOutput("f1_cfg_valid", 64'(cfg_valid), 64'd1);
        @(negedge clk);
        checkOutput("f1_commit_pulse_ends", 64'(commit), 64'd0);
        checkOutput("f1_pending_clear", 64'(pending), 64'd0);

        $display("[TB] frame held until safe");
        safe = 1'b0;
        sendSlots(F2, 5);
        saw_commit = 1'b0;
        repeat (500) begin
            @(negedge clk);
            if (commit) saw_commit = 1'b1;
        end
        checkOutput("f2_no_commit_unsafe", 64'(saw_commit), 64'd0);
        checkOutput("f2_pending_held", 64'(pending), 64'd1);
        checkOutput("f2_params_old", 64'(params), 64'(frameExpect(F1)));
        safe = 1'b1;
        @(negedge clk);
        checkOutput("f2_commit", 64'(commit), 64'd1);
        checkOutput("f2_params", 64'(params), 64'(frameExpect(F2)));
        checkOutput("f2_pending_clear", 64'(pending), 64'd0);

        $display("[TB] skipped slot");
        applyStimulus(3'd5, 8'h01);
        applyStimulus(3'd4, 8'h02);
        applyStimulus(3'd2, 8'h03);
        checkOutput("skip_frame_err", 64'(frame_err), 64'd1);
        @(negedge clk);
        checkOutput("skip_err_pulse_ends", 64'(frame_err), 64'd0);
        sendSlots(F3, 5);
        @(negedge clk);
        checkOutput("f3_commit", 64'(commit), 64'd1);
        checkOutput("f3_params", 64'(params), 64'(frameExpect(F3)));

        $display("[TB] inter-byte timeout");
        applyStimulus(3'd5, 8'h77);
        applyStimulus(3'd4, 8'h88);
        k = 0;
        while (k < 4400 && !frame_err) begin
            @(negedge clk);
            k++;
        end
        $display("[TB] timeout observed %0d cycles after last byte", k);
        checkOutput("timeout_near_4160", 64'((k >= 4158) && (k <= 4164)), 64'd1);
        applyStimulus(3'd3, 8'h99);
        checkOutput("late_byte_frame_err", 64'(frame_err), 64'd1);
        @(negedge clk);
        checkOutput("timeout_params_kept", 64'(params), 64'(frameExpect(F3)));
        checkOutput("timeout_no_pending", 64'(pending), 64'd0);

        $display("[TB] overrun while pending");
        safe = 1'b0;
        sendSlots(F7, 5);
        checkOutput("f7_pending", 64'(pending), 64'd1);
        applyStimulus(3'd5, F4[47:40]);
        checkOutput("overrun_frame_err", 64'(frame_err), 64'd1);
        checkOutput("overrun_pending_drop", 64'(pending), 64'd0);
        checkOutput("overrun_no_commit", 64'(commit), 64'd0);
        safe = 1'b1;
        sendSlots(F4, 4);
        @(negedge clk);
        checkOutput("f4_commit", 64'(commit), 64'd1);
        checkOutput("f4_params", 64'(params), 64'(frameExpect(F4)));

        $display("[TB] new byte and safe in same cycle");
        safe = 1'b0;
        sendSlots(F5, 5);
        @(negedge clk);
        safe       = 1'b1;
        addr_in    = 3'd5;
        data_in    = F6[47:40];
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        checkOutput("same_cycle_commit", 64'(commit), 64'd1);
        checkOutput("same_cycle_no_err", 64'(frame_err), 64'd0);
        checkOutput("same_cycle_params_old", 64'(params), 64'(frameExpect(F5)));
        checkOutput("same_cycle_pending_clear", 64'(pending), 64'd0);
        sendSlots(F6, 4);
        @(negedge clk);
        checkOutput("f6_commit", 64'(commit), 64'd1);
        checkOutput("f6_params", 64'(params), 64'(frameExpect(F6)));

`ifdef CONF_LOADER_CHECKSUM_EN
        $display("[TB] checksum frames");
        applyStimulus(3'd5, 8'h01);
        applyStimulus(3'd4, 8'h02);
        applyStimulus(3'd3, 8'h04);
        applyStimulus(3'd2, 8'h08);
        applyStimulus(3'd1, 8'h10);
        applyStimulus(3'd0, 8'h1F);
        checkOutput("csum_good_no_err", 64'(frame_err), 64'd0);
        @(negedge clk);
        checkOutput("csum_good_commit", 64'(commit), 64'd1);
        checkOutput("csum_good_params", 64'(params), 64'h010204081000);
        applyStimulus(3'd5, 8'h01);
        applyStimulus(3'd4, 8'h02);
        applyStimulus(3'd3, 8'h04);
        applyStimulus(3'd2, 8'h08);
        applyStimulus(3'd1, 8'h10);
        applyStimulus(3'd0, 8'h1E);
        checkOutput("csum_bad_err", 64'(frame_err), 64'd1);
        checkOutput("csum_bad_no_pending", 64'(pending), 64'd0);
        @(negedge clk);
        checkOutput("csum_bad_no_commit", 64'(commit), 64'd0);
        checkOutput("csum_bad_params_kept", 64'(params), 64'h010204081000);
`endif

        $display("[TB] asynchronous reset mid-frame");
        applyStimulus(3'd5, 8'h42);
        applyStimulus(3'd4, 8'h43);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_load_params", 64'(params), 64'd0);
        checkOutput("rst_load_cfg_valid", 64'(cfg_valid), 64'd0);
        rst = 1'b0;
        sendSlots(F1, 5);
        @(negedge clk);
        checkOutput("post_rst_commit", 64'(commit), 64'd1);

        $display("[TB] asynchronous reset while pending");
        safe = 1'b0;
        sendSlots(F2, 5);
        checkOutput("pre_rst_pending", 64'(pending), 64'd1);
        #3 rst = 1'b1;
        #1;
        checkOutput("rst_pend_pending", 64'(pending), 64'd0);
        checkOutput("rst_pend_params", 64'(params), 64'd0);
        checkOutput("rst_pend_cfg_valid", 64'(cfg_valid), 64'd0);
        rst = 1'b0;
        applyStimulus(3'd4, 8'h55);
        checkOutput("rst_state_idle_err", 64'(frame_err), 64'd1);
        safe = 1'b1;
        sendSlots(F1, 5);
        @(negedge clk);
        checkOutput("rst_lost_frame_commit", 64'(commit), 64'd1);
        checkOutput("rst_lost_frame_params", 64'(params), 64'(frameExpect(F1)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_cnt, mismatch_cnt);
        $finish;
    end

endmodule
